// File: rtl/factocore_pkg.sv
// Shared constants, port-ID encoding and helpers for the FactoCore register bank.
package factocore_pkg;

    localparam int unsigned DW   = 65;
    localparam int unsigned NREG = 7;
    localparam int unsigned AW   = 3;

    typedef logic port_id_t;

    localparam port_id_t PORT_H = 1'b0;
    localparam port_id_t PORT_C = 1'b1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } wr_req_t;

    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
        logic [NREG-1:0] dec;
        dec = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            dec[i] = (addr == AW'(i));
        end
        return dec;
    endfunction

    function automatic logic addr_legal(input logic [AW-1:0] addr);
        return (32'(addr) < NREG);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the port that was not granted last.
module rr_arb2
    import factocore_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     elig_h,
    input  logic     elig_c,
    output logic     gnt_vld_c,
    output port_id_t gnt_port_c
);

    port_id_t rr_last;

    always_comb begin
        gnt_vld_c  = elig_h | elig_c;
        gnt_port_c = PORT_H;
        if (elig_h && elig_c) begin
            gnt_port_c = (rr_last == PORT_H) ? PORT_C : PORT_H;
        end else if (elig_c) begin
            gnt_port_c = PORT_C;
        end
    end

    // Resetting to H lets the core win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= PORT_H;
        end else if (gnt_vld_c) begin
            rr_last <= gnt_port_c;
        end
    end

endmodule

// File: rtl/reg_wr_sched.sv
// Write scheduler for the 7-entry register bank: arbitrates host and core writers
// and drives the one-hot enable vector and shared data bus from registers.
module reg_wr_sched
    import factocore_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            h_req,
    input  logic [AW-1:0]   h_addr,
    input  logic [DW-1:0]   h_wdata,
    output logic            h_ack,
    input  logic            c_req,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    output logic            c_ack,
    input  logic            lock,
    output logic [NREG-1:0] en,
    output logic [DW-1:0]   d_in,
    output logic            addr_err,
    output logic            busy
);

    logic     elig_h_c;
    logic     elig_c_c;
    logic     gnt_vld_c;
    port_id_t gnt_port_c;
    wr_req_t  gnt_req_c;
    logic     gnt_ok_c;

    // A port is masked in its own ack cycle so a still-high request is not granted twice.
    assign elig_h_c = h_req & ~lock & ~h_ack;
    assign elig_c_c = c_req & ~c_ack;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .elig_h     (elig_h_c),
        .elig_c     (elig_c_c),
        .gnt_vld_c  (gnt_vld_c),
        .gnt_port_c (gnt_port_c)
    );

    always_comb begin
        gnt_req_c = '{addr: h_addr, wdata: h_wdata};
        if (gnt_port_c == PORT_C) begin
            gnt_req_c = '{addr: c_addr, wdata: c_wdata};
        end
        gnt_ok_c = addr_legal(gnt_req_c.addr);
    end

    // Output registers; d_in keeps its value unless a legal write is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_ack    <= 1'b0;
            c_ack    <= 1'b0;
            en       <= '0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
            d_in     <= '0;
        end else begin
            h_ack    <= gnt_vld_c & (gnt_port_c == PORT_H);
            c_ack    <= gnt_vld_c & (gnt_port_c == PORT_C);
            en       <= (gnt_vld_c & gnt_ok_c) ? onehot_dec(gnt_req_c.addr) : '0;
            busy     <= gnt_vld_c & gnt_ok_c;
            addr_err <= gnt_vld_c & ~gnt_ok_c;
            if (gnt_vld_c && gnt_ok_c) begin
                d_in <= gnt_req_c.wdata;
            end
        end
    end

endmodule
